info_ram_reader: RTL and testbench

- Read-side controller for the transmit info block RAM, a simple dual-port RAM with 2-cycle registered read.
- Issues read addresses and enables, and handles the 2-cycle read latency with a one-word prefetch.
- Unpacks each RAM_WIDTH-bit word into SYM_BITS-bit QPSK symbols, MSB first.
- Streams the symbols to the mapper over a valid/ready handshake. It sits between the info RAM and the QPSK symbol mapper.

---
 rtl/info_ram_reader.sv | 179 +++++++++++++++++
 tb/tb_info_ram_reader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/info_ram_reader.sv
// Read-side controller for the transmit info RAM: issues 2-cycle-latency reads with a
// one-word prefetch and streams MSB-first symbols to the mapper over valid/ready.
module info_ram_reader #(
    parameter int unsigned RAM_EXP   = 15,
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned SYM_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_loop,
    input  logic [RAM_EXP:0]     i_num_words,
    output logic [RAM_EXP-1:0]   o_addr_r,
    output logic                 o_read_enb,
    output logic                 o_out_enb,
    output logic                 o_out_rst,
    input  logic [RAM_WIDTH-1:0] i_data_ram,
    output logic [SYM_BITS-1:0]  o_sym,
    output logic                 o_sym_valid,
    input  logic                 i_sym_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned SYMS  = RAM_WIDTH / SYM_BITS;
    localparam int unsigned IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(SYMS - 1);
    localparam logic [RAM_EXP:0]   MAX_WORDS = {1'b1, {RAM_EXP{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_STREAM
    } state_t;

    state_t               state;
    logic [RAM_EXP:0]     num_words;
    logic                 loop_mode;
    logic [RAM_EXP:0]     rd_cnt;
    logic [RAM_WIDTH-1:0] shift_reg;
    logic [RAM_WIDTH-1:0] pf_buf;
    logic                 pf_valid;
    logic                 land;
    logic [IDX_W-1:0]     sym_idx;

    logic                 inflight;
    logic                 hs;
    logic                 last_sym;
    logic                 words_left;
    logic                 issue;
    logic                 all_read;
    logic                 land_to_sr;
    logic [RAM_EXP-1:0]   last_addr;
    logic [RAM_EXP-1:0]   next_addr;

    assign o_out_rst = i_rst;
    assign o_sym     = shift_reg[RAM_WIDTH-1 -: SYM_BITS];

    // A read occupies three cycles: enable, output-register enable, data landing.
    always_comb begin
        inflight   = o_read_enb | o_out_enb | land;
        hs         = o_sym_valid & i_sym_ready;
        last_sym   = (sym_idx == LAST_IDX);
        words_left = loop_mode | (rd_cnt < num_words);
        issue      = (state == S_STREAM) & ~pf_valid & ~inflight & words_left;
        all_read   = ~loop_mode & (rd_cnt == num_words);
        land_to_sr = land & ((hs & last_sym & ~pf_valid) | ~o_sym_valid);
        last_addr  = num_words[RAM_EXP-1:0] - RAM_EXP'(1);
        next_addr  = (loop_mode && (o_addr_r == last_addr)) ? '0 : o_addr_r + RAM_EXP'(1);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            num_words   <= '0;
            loop_mode   <= 1'b0;
            rd_cnt      <= '0;
            shift_reg   <= '0;
            pf_buf      <= '0;
            pf_valid    <= 1'b0;
            land        <= 1'b0;
            sym_idx     <= '0;
            o_addr_r    <= '0;
            o_read_enb  <= 1'b0;
            o_out_enb   <= 1'b0;
            o_sym_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_read_enb <= 1'b0;
            o_out_enb  <= o_read_enb;
            land       <= o_out_enb;

            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop && (i_num_words != '0)) begin
                        num_words  <= (i_num_words > MAX_WORDS) ? MAX_WORDS : i_num_words;
                        loop_mode  <= i_loop;
                        o_addr_r   <= '0;
                        o_read_enb <= 1'b1;
                        rd_cnt     <= (RAM_EXP+1)'(1);
                        sym_idx    <= '0;
                        pf_valid   <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= S_FETCH;
                    end
                end

                S_FETCH: state <= S_WAIT;

                S_WAIT: state <= S_LOAD;

                S_LOAD: begin
                    shift_reg   <= i_data_ram;
                    sym_idx     <= '0;
                    o_sym_valid <= 1'b1;
                    state       <= S_STREAM;
                end

                S_STREAM: begin
                    if (issue) begin
                        o_read_enb <= 1'b1;
                        o_addr_r   <= next_addr;
                        rd_cnt     <= rd_cnt + (RAM_EXP+1)'(1);
                    end

                    // Word boundary: buffer first, then data landing this edge, else stall or finish.
                    if (hs && !last_sym) begin
                        shift_reg <= shift_reg << SYM_BITS;
                        sym_idx   <= sym_idx + IDX_W'(1);
                    end else if (hs && last_sym) begin
                        if (pf_valid) begin
                            shift_reg <= pf_buf;
                            pf_valid  <= 1'b0;
                            sym_idx   <= '0;
                        end else if (land) begin
                            shift_reg <= i_data_ram;
                            sym_idx   <= '0;
                        end else if (all_read && !inflight) begin
                            o_done      <= 1'b1;
                            o_sym_valid <= 1'b0;
                            o_busy      <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            o_sym_valid <= 1'b0;
                        end
                    end else if (!o_sym_valid && land) begin
                        shift_reg   <= i_data_ram;
                        sym_idx     <= '0;
                        o_sym_valid <= 1'b1;
                    end

                    if (land && !land_to_sr) begin
                        pf_buf   <= i_data_ram;
                        pf_valid <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase

            if (i_stop && (state != S_IDLE)) begin
                state       <= S_IDLE;
                o_sym_valid <= 1'b0;
                o_busy      <= 1'b0;
                o_done      <= 1'b0;
                o_read_enb  <= 1'b0;
                o_out_enb   <= 1'b0;
                land        <= 1'b0;
                pf_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_info_ram_reader.sv
// Directed bench for info_ram_reader with a 2-cycle registered RAM model; small RAM_EXP
// keeps the clamp and full-depth scenarios short.
module tb_info_ram_reader;

    localparam int unsigned RAM_EXP   = 4;
    localparam int unsigned RAM_WIDTH = 32;
    localparam int unsigned SYM_BITS  = 2;

    logic                 clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 i_stop = 1'b0;
    logic                 i_loop = 1'b0;
    logic [RAM_EXP:0]     i_num_words = '0;
    logic [RAM_EXP-1:0]   o_addr_r;
    logic                 o_read_enb;
    logic                 o_out_enb;
    logic                 o_out_rst;
    logic [RAM_WIDTH-1:0] i_data_ram;
    logic [SYM_BITS-1:0]  o_sym;
    logic                 o_sym_valid;
    logic                 i_sym_ready = 1'b1;
    logic                 o_busy;
    logic                 o_done;

    int vectors = 0;
    int miscompares = 0;

    logic [RAM_WIDTH-1:0] mem [16];
    logic [RAM_WIDTH-1:0] rd_q;
    int                   rd_log[$];

    info_ram_reader #(
        .RAM_EXP  (RAM_EXP),
        .RAM_WIDTH(RAM_WIDTH),
        .SYM_BITS (SYM_BITS)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_loop     (i_loop),
        .i_num_words(i_num_words),
        .o_addr_r   (o_addr_r),
        .o_read_enb (o_read_enb),
        .o_out_enb  (o_out_enb),
        .o_out_rst  (o_out_rst),
        .i_data_ram (i_data_ram),
        .o_sym      (o_sym),
        .o_sym_valid(o_sym_valid),
        .i_sym_ready(i_sym_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_read_enb) rd_q <= mem[o_addr_r];
        if (o_out_rst) i_data_ram <= '0;
        else if (o_out_enb) i_data_ram <= rd_q;
    end

    always @(negedge clk) begin
        if (o_read_enb) rd_log.push_back(int'(o_addr_r));
    end

    task automatic start_run(input int nw, input logic lp);
        @(negedge clk);
        i_start     = 1'b1;
        i_num_words = (RAM_EXP+1)'(nw);
        i_loop      = lp;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_addr_r, o_read_enb, o_out_enb, o_sym, o_sym_valid, o_busy, o_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%0h re=%b oe=%b sym=%0d v=%b busy=%b done=%b expected all 0",
                     o_addr_r, o_read_enb, o_out_enb, o_sym, o_sym_valid, o_busy, o_done);
        end
        vectors++;
        if (o_out_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_out_rst: got %b expected 1", o_out_rst);
        end
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        logic [1:0] exp;
        mem[0] = 32'hE4E4E4E4;
        i_sym_ready = 1'b1;
        rd_log.delete();
        start_run(1, 1'b0);
        vectors++;
        if (o_read_enb !== 1'b1 || o_addr_r !== 4'd0 || o_busy !== 1'b1 || o_sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_fetch: got re=%b addr=%0d busy=%b v=%b expected 1 0 1 0",
                     o_read_enb, o_addr_r, o_busy, o_sym_valid);
        end
        @(negedge clk);
        vectors++;
        if (o_out_enb !== 1'b1 || o_sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_wait: got oe=%b v=%b expected 1 0", o_out_enb, o_sym_valid);
        end
        @(negedge clk);
        vectors++;
        if (o_sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_load: got v=%b expected 0", o_sym_valid);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp = 2'(3 - (k % 4));
            vectors++;
            if (o_sym_valid !== 1'b1 || o_sym !== exp || o_done !== 1'b0) begin
                miscompares++;
                $display("FAIL single_sym%0d: got v=%b sym=%0d done=%b expected 1 %0d 0",
                         k, o_sym_valid, o_sym, o_done, exp);
            end
        end
        @(negedge clk);
        vectors++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got done=%b busy=%b v=%b expected 1 0 0", o_done, o_busy, o_sym_valid);
        end
        @(negedge clk);
        vectors++;
        if (o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_pulse: got done=%b expected 0", o_done);
        end
    endtask

    task automatic test_throughput;
        logic [1:0] exp;
        mem[0] = 32'h00000000;
        mem[1] = 32'hFFFFFFFF;
        mem[2] = 32'h55555555;
        i_sym_ready = 1'b1;
        rd_log.delete();
        start_run(3, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k < 16) ? 2'd0 : (k < 32) ? 2'd3 : 2'd1;
            vectors++;
            if (o_sym_valid !== 1'b1 || o_sym !== exp) begin
                miscompares++;
                $display("FAIL thru_sym%0d: got v=%b sym=%0d expected 1 %0d", k, o_sym_valid, o_sym, exp);
            end
        end
        @(negedge clk);
        vectors++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_sym_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL thru_done: got done=%b busy=%b v=%b expected 1 0 0", o_done, o_busy, o_sym_valid);
        end
        vectors++;
        if (rd_log.size() != 3) begin
            miscompares++;
            $display("FAIL thru_reads: got %0d reads expected 3", rd_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (rd_log[i] != i) begin
                    miscompares++;
                    $display("FAIL thru_addr%0d: got %0d expected %0d", i, rd_log[i], i);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat = 4'b1001;
        int         hs_cnt = 0;
        logic       done_seen = 1'b0;
        logic       stall_prev = 1'b0;
        logic [1:0] prev_sym = '0;
        mem[0] = 32'h1B1B1B1B;
        rd_log.delete();
        start_run(1, 1'b0);
        for (int t = 0; t < 200 && !done_seen; t++) begin
            if (t > 0) @(negedge clk);
            i_sym_ready = pat[t % 4];
            if (stall_prev) begin
                vectors++;
                if (o_sym_valid !== 1'b1 || o_sym !== prev_sym) begin
                    miscompares++;
                    $display("FAIL bp_hold: got v=%b sym=%0d expected 1 %0d", o_sym_valid, o_sym, prev_sym);
                end
            end
            if (o_done === 1'b1) begin
                done_seen = 1'b1;
            end else if (o_sym_valid === 1'b1 && i_sym_ready) begin
                vectors++;
                if (o_sym !== 2'(hs_cnt % 4)) begin
                    miscompares++;
                    $display("FAIL bp_sym%0d: got %0d expected %0d", hs_cnt, o_sym, hs_cnt % 4);
                end
                hs_cnt++;
            end
            stall_prev = o_sym_valid && !i_sym_ready;
            prev_sym   = o_sym;
        end
        vectors++;
        if (!done_seen || hs_cnt != 16) begin
            miscompares++;
            $display("FAIL bp_count: got done=%b handshakes=%0d expected 1 16", done_seen, hs_cnt);
        end
        i_sym_ready = 1'b1;
    endtask

    task automatic test_loop;
        logic [1:0] exp;
        mem[0] = 32'hFFFFFFFF;
        mem[1] = 32'h00000000;
        i_sym_ready = 1'b1;
        rd_log.delete();
        start_run(2, 1'b1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            exp = (((k / 16) % 2) == 0) ? 2'd3 : 2'd0;
            vectors++;
            if (o_sym_valid !== 1'b1 || o_sym !== exp || o_done !== 1'b0) begin
                miscompares++;
                $display("FAIL loop_sym%0d: got v=%b sym=%0d done=%b expected 1 %0d 0",
                         k, o_sym_valid, o_sym, o_done, exp);
            end
        end
        vectors++;
        if (rd_log.size() < 4) begin
            miscompares++;
            $display("FAIL loop_reads: got %0d reads expected at least 4", rd_log.size());
        end
        foreach (rd_log[i]) begin
            vectors++;
            if (rd_log[i] != (i % 2)) begin
                miscompares++;
                $display("FAIL loop_addr%0d: got %0d expected %0d", i, rd_log[i], i % 2);
            end
        end
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        vectors++;
        if (o_sym_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_stop: got v=%b busy=%b done=%b expected 0 0 0", o_sym_valid, o_busy, o_done);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (o_done !== 1'b0 || o_read_enb !== 1'b0 || o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL loop_after_stop%0d: got done=%b re=%b busy=%b expected 0 0 0",
                         k, o_done, o_read_enb, o_busy);
            end
        end
    endtask

    task automatic test_clamp;
        int   hs_cnt = 0;
        logic done_seen = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h01010101;
        i_sym_ready = 1'b1;
        rd_log.delete();
        start_run(20, 1'b0);
        for (int t = 0; t < 400 && !done_seen; t++) begin
            if (t > 0) @(negedge clk);
            if (o_done === 1'b1) done_seen = 1'b1;
            else if (o_sym_valid === 1'b1) hs_cnt++;
        end
        vectors++;
        if (!done_seen || hs_cnt != 256) begin
            miscompares++;
            $display("FAIL clamp_count: got done=%b symbols=%0d expected 1 256", done_seen, hs_cnt);
        end
        vectors++;
        if (rd_log.size() != 16) begin
            miscompares++;
            $display("FAIL clamp_reads: got %0d reads expected 16", rd_log.size());
        end else begin
            foreach (rd_log[i]) begin
                vectors++;
                if (rd_log[i] != i) begin
                    miscompares++;
                    $display("FAIL clamp_addr%0d: got %0d expected %0d", i, rd_log[i], i);
                end
            end
        end
    endtask

    task automatic test_edge_cases;
        rd_log.delete();
        start_run(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_read_enb !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_words%0d: got busy=%b done=%b re=%b expected 0 0 0",
                         k, o_busy, o_done, o_read_enb);
            end
            @(negedge clk);
        end
        vectors++;
        if (rd_log.size() != 0) begin
            miscompares++;
            $display("FAIL zero_reads: got %0d reads expected 0", rd_log.size());
        end

        mem[0] = 32'hE4E4E4E4;
        mem[1] = 32'h1B1B1B1B;
        i_sym_ready = 1'b1;
        start_run(2, 1'b0);
        repeat (8) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({o_addr_r, o_read_enb, o_out_enb, o_sym, o_sym_valid, o_busy, o_done} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got addr=%0h re=%b oe=%b sym=%0d v=%b busy=%b done=%b expected all 0",
                     o_addr_r, o_read_enb, o_out_enb, o_sym, o_sym_valid, o_busy, o_done);
        end
        i_rst = 1'b0;
        @(negedge clk);
        rd_log.delete();
        start_run(1, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (o_sym_valid !== 1'b1 || o_sym !== 2'd3 || rd_log.size() < 1 || rd_log[0] != 0) begin
            miscompares++;
            $display("FAIL replay: got v=%b sym=%0d reads=%0d expected 1 3 first addr 0",
                     o_sym_valid, o_sym, rd_log.size());
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_throughput();
        test_backpressure();
        test_loop();
        test_clamp();
        test_edge_cases();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
